uart_tx_fifo_reader: RTL and testbench

//  UART transmit engine on the read side of the TX async FIFO, in the rclk domain.

---
 rtl/uart_tx_fifo_reader.sv | 132 +++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_reader.sv
// UART transmit engine on the read side of the TX async FIFO: pops one word per
// frame and serialises it as start bit, LSB-first data, optional parity and stop bits.
module uart_tx_fifo_reader #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             tx_en,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [BIT_W-1:0]  bit_cnt, bit_next;
    logic [WIDTH-1:0]  shreg, shreg_next;
    logic              par, par_next;
    logic              tx_next, busy_next, done_next;
    logic              bit_end;

    assign rinc    = (state == IDLE) & tx_en & ~empty & ~rrst;
    assign bit_end = (baud_cnt == BAUD_LAST);

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        baud_next  = bit_end ? '0 : baud_cnt + 1'b1;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        par_next   = par;

        unique case (state)
            IDLE: begin
                baud_next = '0;
                if (rinc) state_next = FETCH;
            end
            FETCH: begin
                // The FIFO RAM registered rdata on the rinc edge; it is valid only now.
                baud_next  = '0;
                shreg_next = rdata;
                par_next   = (^rdata) ^ (PARITY_ODD != 0);
                state_next = START;
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_next   = '0;
                        state_next = IDLE;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are registered, so they are derived from the upcoming state.
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = par_next;
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == STOP) && (baud_next == BAUD_LAST) && (bit_next == STOP_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates together.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            par      <= par_next;
            tx       <= tx_next;
            tx_busy  <= busy_next;
            tx_done  <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: queue-based FIFO model feeding two DUTs
// (even/1 stop and odd/2 stop), with frames checked cycle by cycle against a bit list.
module tb_uart_tx_fifo_reader;
    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rrst = 1'b1;
    logic       tx_en_a = 1'b0, empty_a = 1'b1;
    logic [7:0] rdata_a = 8'h00;
    logic       rinc_a, tx_a, tx_busy_a, tx_done_a;
    logic       tx_en_b = 1'b0, empty_b = 1'b1;
    logic [7:0] rdata_b = 8'h00;
    logic       rinc_b, tx_b, tx_busy_b, tx_done_b;

    logic [7:0] fifo_a[$];
    logic [7:0] fifo_b[$];
    logic [7:0] burst_w[8];

    int cyc = 0;
    int rinc_cnt_a = 0, rinc_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int last_rinc_a = 0, last_rinc_b = 0;
    int errors = 0, checks = 0;

    uart_tx_fifo_reader #(
        .WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .rclk(clk), .rrst(rrst), .tx_en(tx_en_a), .empty(empty_a), .rdata(rdata_a),
        .rinc(rinc_a), .tx(tx_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a)
    );

    uart_tx_fifo_reader #(
        .WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dut_b (
        .rclk(clk), .rrst(rrst), .tx_en(tx_en_b), .empty(empty_b), .rdata(rdata_b),
        .rinc(rinc_b), .tx(tx_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
    );

    // FIFO model: the read word appears on rdata the edge after rinc & ~empty.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rinc_a) begin
            rinc_cnt_a  <= rinc_cnt_a + 1;
            last_rinc_a <= cyc;
        end
        if (rinc_b) begin
            rinc_cnt_b  <= rinc_cnt_b + 1;
            last_rinc_b <= cyc;
        end
        if (tx_done_a) done_cnt_a <= done_cnt_a + 1;
        if (tx_done_b) done_cnt_b <= done_cnt_b + 1;
        if (rinc_a && !empty_a) rdata_a <= fifo_a.pop_front();
        if (rinc_b && !empty_b) rdata_b <= fifo_b.pop_front();
        empty_a <= (fifo_a.size() == 0);
        empty_b <= (fifo_b.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] line_state(input bit sel);
        return sel ? {tx_b, tx_busy_b, tx_done_b} : {tx_a, tx_busy_a, tx_done_a};
    endfunction

    // Waits (bounded) for the start bit and checks it lands two cycles after rinc.
    task automatic wait_fall(input bit sel, output int fall);
        logic [2:0] ls;
        fall = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ls = line_state(sel);
            if (ls[2] == 1'b0) begin
                fall = cyc;
                break;
            end
        end
        check("frame_start_seen", 32'(fall >= 0), 32'd1);
        check("start_latency", fall - (sel ? last_rinc_b : last_rinc_a), 32'd2);
    endtask

    // Reference frame: start 0, data LSB first, parity from the ones count, stop 1s.
    task automatic check_frame(input bit sel, input logic [7:0] word, input int odd,
                               input int stops, output int start_c, output int end_c);
        bit         exp_q[$];
        logic [2:0] ls;
        bit         last;
        wait_fall(sel, start_c);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(word[i]);
        exp_q.push_back(1'(($countones(word) + odd) % 2));
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
        for (int b = 0; b < exp_q.size(); b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                ls   = line_state(sel);
                last = (b == exp_q.size() - 1) && (c == CPB - 1);
                check($sformatf("frame_%02h_bit%0d", word, b), 32'(ls), 32'({exp_q[b], 1'b1, last}));
            end
        end
        end_c = cyc;
        @(negedge clk);
        check($sformatf("after_frame_%02h", word), 32'(line_state(sel)), 32'b100);
    endtask

    // Pushes n words at once; frames must follow with exactly 2 idle-high cycles between.
    task automatic run_burst(input int n, input string tag);
        int s, e, prev_e, r0, d0;
        r0 = rinc_cnt_a;
        d0 = done_cnt_a;
        for (int i = 0; i < n; i++) fifo_a.push_back(burst_w[i]);
        prev_e = 0;
        for (int i = 0; i < n; i++) begin
            check_frame(1'b0, burst_w[i], 0, 1, s, e);
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), s - prev_e, 32'd3);
            prev_e = e;
        end
        check($sformatf("%s_rinc", tag), rinc_cnt_a - r0, n);
        check($sformatf("%s_done", tag), done_cnt_a - d0, n);
    endtask

    initial begin
        int s, e, r0, d0, bad;
        logic [7:0] w1, w2;

        // Reset with a word already queued: rinc must stay low while rrst is high.
        tx_en_a = 1'b1;
        tx_en_b = 1'b1;
        fifo_a.push_back(8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("reset_a", 32'({rinc_a, tx_a, tx_busy_a, tx_done_a}), 32'b0100);
        end
        check("reset_b", 32'({rinc_b, tx_b, tx_busy_b, tx_done_b}), 32'b0100);

        // 0xA5, even parity, one stop bit.
        r0 = rinc_cnt_a;
        d0 = done_cnt_a;
        rrst = 1'b0;
        check_frame(1'b0, 8'hA5, 0, 1, s, e);
        check("a5_len", e - s + 1, 32'd176);
        check("a5_rinc", rinc_cnt_a - r0, 32'd1);
        check("a5_done", done_cnt_a - d0, 32'd1);

        // Empty FIFO with tx_en high: the line stays quiet.
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (rinc_a || !tx_a || tx_busy_a || tx_done_a) bad++;
        end
        check("empty_quiet", bad, 32'd0);
        check("empty_no_rinc", rinc_cnt_a - r0, 32'd1);

        // Three words pushed together, then a random burst.
        burst_w[0] = 8'h00;
        burst_w[1] = 8'hFF;
        burst_w[2] = 8'h55;
        run_burst(3, "burst3");
        for (int i = 0; i < 4; i++) burst_w[i] = 8'($urandom);
        run_burst(4, "rand4");

        // tx_en dropped during data bit 2: frame 1 completes, word 2 stays queued.
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        r0 = rinc_cnt_a;
        fifo_a.push_back(w1);
        fifo_a.push_back(w2);
        fork
            check_frame(1'b0, w1, 0, 1, s, e);
            begin
                repeat (55) @(negedge clk);
                tx_en_a = 1'b0;
            end
        join
        repeat (40) @(negedge clk);
        check("txen_low_rinc", rinc_cnt_a - r0, 32'd1);
        check("txen_low_line", 32'(line_state(1'b0)), 32'b100);
        check("txen_low_empty", 32'(empty_a), 32'd0);
        tx_en_a = 1'b1;
        check_frame(1'b0, w2, 0, 1, s, e);
        check("txen_resume_rinc", rinc_cnt_a - r0, 32'd2);

        // One-cycle rrst during data bit 3: frame abandoned, next word freshly popped.
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        r0 = rinc_cnt_a;
        d0 = done_cnt_a;
        fifo_a.push_back(w1);
        fifo_a.push_back(w2);
        wait_fall(1'b0, s);
        repeat (66) @(negedge clk);
        rrst = 1'b1;
        @(negedge clk);
        check("midframe_reset", 32'(line_state(1'b0)), 32'b100);
        rrst = 1'b0;
        check_frame(1'b0, w2, 0, 1, s, e);
        check("midframe_reset_rinc", rinc_cnt_a - r0, 32'd2);
        check("midframe_reset_done", done_cnt_a - d0, 32'd1);

        // Odd parity, two stop bits.
        r0 = rinc_cnt_b;
        d0 = done_cnt_b;
        fifo_b.push_back(8'h01);
        check_frame(1'b1, 8'h01, 1, 2, s, e);
        check("odd2_len", e - s + 1, 32'd192);
        w1 = 8'($urandom);
        fifo_b.push_back(w1);
        check_frame(1'b1, w1, 1, 2, s, e);
        check("odd2_rinc", rinc_cnt_b - r0, 32'd2);
        check("odd2_done", done_cnt_b - d0, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached after %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
